// File: rtl/mem_arbiter_responder.sv
// Round-robin arbiter of NUM_PORTS engine ports onto one memory port,
// with in-order read tag tracking. Optional: ARB_PERF_EN (stall counter).
module mem_arbiter_responder #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 64,
    parameter int TAG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          p_req,
    input  logic [NUM_PORTS-1:0]          p_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata,
    output logic [NUM_PORTS-1:0]          p_gnt,
    output logic [NUM_PORTS-1:0]          p_valid,
    output logic [DATA_W-1:0]             p_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_sticky,
    output logic [63:0]                   perf_stall_cycles
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] hi_idx;
    logic [PW-1:0] lo_idx;
    logic          hi_found;
    logic          lo_found;
    logic          cand_we;
    logic          full;
    logic          empty;
    logic          blocked;
    logic          grant;
    logic          push;
    logic          pop;

    logic [PW-1:0] tag_mem [TAG_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_tag;
    logic [NUM_PORTS-1:0] rsp_onehot;

    assign full  = (count == CW'(TAG_DEPTH));
    assign empty = (count == '0);
    assign outstanding = count;
    assign rd_tag = tag_mem[rd_ptr];

    // First requester at or above rr_ptr, else lowest requester (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (p_req[i]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = PW'(i);
                end
                if (!hi_found && (i >= int'(rr_ptr))) begin
                    hi_found = 1'b1;
                    hi_idx   = PW'(i);
                end
            end
        end
        cand = hi_found ? hi_idx : lo_idx;
    end

    // Mux the candidate's beat; a full FIFO stalls only read candidates.
    always_comb begin
        cand_we   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cand == PW'(i)) begin
                cand_we   = p_we[i];
                mem_addr  = p_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = p_wdata[i*DATA_W +: DATA_W];
            end
        end
        blocked = !cand_we && full && !mem_rvalid;
        mem_req = rst_n && lo_found && !blocked;
        mem_we  = cand_we;
    end

    assign grant = mem_req & mem_ready;
    assign push  = grant & ~cand_we;
    assign pop   = mem_rvalid & ~empty;

    // Decode grant and response tag into one-hot port vectors.
    always_comb begin
        p_gnt      = '0;
        rsp_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            p_gnt[i]      = grant && (cand == PW'(i));
            rsp_onehot[i] = (rd_tag == PW'(i));
        end
    end

    // Advance the round-robin pointer past each granted port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (cand == PW'(NUM_PORTS-1)) ? '0 : cand + PW'(1);
        end
    end

    // Tag storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= cand;
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Route read data to the issuing port; flag orphan responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid    <= '0;
            p_rdata    <= '0;
            err_sticky <= 1'b0;
        end else begin
            p_valid <= pop ? rsp_onehot : '0;
            if (pop) begin
                p_rdata <= mem_rdata;
            end
            if (mem_rvalid && empty) begin
                err_sticky <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_EN
    // Count cycles where someone requests but nobody is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
        end else if ((|p_req) && !(|p_gnt)) begin
            perf_stall_cycles <= perf_stall_cycles + 64'd1;
        end
    end
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: doc/mem_arbiter_responder.md
Name: mem_arbiter_responder

Overview:
- Responder end of the core-side arbiter bus used by each NTT engine (req/we/addr/wdata in; gnt/valid/rdata out).
- Round-robin arbitrates NUM_PORTS engine ports onto one backend memory port.
- Tracks in-flight reads in an in-order tag FIFO and routes each read response back to the issuing port.

Parameters:
- NUM_PORTS, 2, number of engine ports; legal range 1..8.
- ADDR_W, 48, byte address width.
- DATA_W, 64, data word width.
- TAG_DEPTH, 16, max outstanding reads; power of 2, at least 2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- p_req  in  NUM_PORTS  per-port request.
- p_we  in  NUM_PORTS  per-port write enable (1 = write).
- p_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- p_wdata  in  NUM_PORTS*DATA_W  per-port write data; same slicing.
- p_gnt  out  NUM_PORTS  combinational grant, one-hot or zero.
- p_valid  out  NUM_PORTS  registered read-response strobe, one-hot or zero.
- p_rdata  out  DATA_W  registered read data, shared by all ports.
- mem_req  out  1  backend request (combinational).
- mem_we  out  1  backend write enable.
- mem_addr  out  ADDR_W  backend address.
- mem_wdata  out  DATA_W  backend write data.
- mem_ready  in  1  backend accepts a beat this cycle when mem_req is high.
- mem_rvalid  in  1  backend read data valid; responses return in order.
- mem_rdata  in  DATA_W  backend read data.
- outstanding  out  $clog2(TAG_DEPTH)+1  reads issued but not yet answered.
- err_sticky  out  1  protocol error flag.
- perf_stall_cycles  out  64  stall counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): rr_ptr=0, tag FIFO empty, outstanding=0, p_valid=0, p_rdata=0, err_sticky=0, perf_stall_cycles=0. While in reset, p_gnt=0 and mem_req=0.
- Arbitration (combinational):
  - Candidate = first port with p_req=1, searching from rr_ptr upward and wrapping.
  - Candidate is eligible if p_we=1, or if the tag FIFO is not full.
  - mem_req=1 when an eligible candidate exists; mem_we/mem_addr/mem_wdata are muxed from that port.
  - A full FIFO blocks only read candidates. The search does not skip past a blocked read candidate to reach a later port (strict RR; no skip).
- Grant: p_gnt[c] = mem_req & mem_ready. A beat transfers exactly on a cycle with req & gnt. Ports may present a new beat in the following cycle.
- rr_ptr: on a granted beat, rr_ptr <= (c+1) mod NUM_PORTS. It is unchanged when there is no grant.
- Tag FIFO:
  - Push the port index on a granted read.
  - Pop on mem_rvalid.
  - Push and pop in the same cycle are legal, including when the FIFO is full (pop frees the slot for that cycle's push: eligibility uses full & ~mem_rvalid).
  - outstanding tracks occupancy: +1 on push, -1 on pop, net 0 on both.
- Response:
  - On mem_rvalid with FIFO non-empty: next cycle p_valid[tag]=1 and p_rdata=mem_rdata (latency 1 from mem_rvalid).
  - p_valid is a one-cycle pulse per response; back-to-back responses are supported.
  - p_rdata holds its last value when p_valid=0.
- Error: mem_rvalid with FIFO empty sets err_sticky=1, drops the data and produces no p_valid. err_sticky is cleared only by reset.
- Writes: no response is generated, and outstanding is unaffected.
- Reset mid-operation: all in-flight tags are discarded. Late mem_rvalid after reset falls under the error rule.
- NUM_PORTS=1: rr_ptr is constant 0.

Optional Feature:
- ARB_PERF_EN defined: perf_stall_cycles increments by 1 every cycle in which |p_req=1 and no p_gnt is asserted (covers both backend not ready and FIFO full). It wraps at 2^64.
- Not defined: perf_stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Single read burst: NUM_PORTS=2, port0 reads 0x1000, 0x1008, 0x1010; backend has latency 2 with mem_ready=1 -> three gnt cycles, then p_valid[0] 3 pulses carrying data in issue order; p_valid[1]=0; outstanding peaks at 2.
- Contention: both ports hold req continuously with reads, mem_ready=1 -> grants alternate 0,1,0,1. Each port's responses return only on its own p_valid, in order.
- FIFO full: TAG_DEPTH=4, backend withholds rvalid, port0 requests 6 reads -> exactly 4 grants, then mem_req=0 and outstanding=4. A write from port1 in the same stall window is still granted. One rvalid -> exactly one further read grant, which may land in the same cycle.
- Backpressure: mem_ready=0 for 5 cycles with port1 req=1 -> p_gnt=0 throughout; with ARB_PERF_EN defined, perf_stall_cycles=5. The beat is granted the cycle mem_ready rises.
- Protocol error: mem_rvalid pulse with outstanding=0 -> err_sticky=1 next cycle, no p_valid; err_sticky holds until rst_n=0.
- Reset mid-burst: assert rst_n=0 with outstanding=3 -> outstanding=0 and p_valid=0 immediately. A subsequent read from port0 completes normally.
